// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states,
// word width and the alignment rule.
package mem_pkg;

  localparam int WORD_BITS = 32;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Halfwords need an even byte address, words a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic result;
    case (size_e'(size))
      SZ_BYTE: result = 1'b0;
      SZ_HALF: result = offset[0];
      SZ_WORD: result = |offset;
      default: result = 1'b1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword from a stored word and sign- or
// zero-extends it to 32 bits; word loads pass straight through.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [WORD_BITS-1:0] word,
  input  logic [1:0]           offset,
  input  logic [1:0]           size,
  input  logic                 unsigned_ld,
  output logic [WORD_BITS-1:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[8*offset +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    value  = '0;
    case (size_e'(size))
      SZ_BYTE: value = unsigned_ld ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: value = unsigned_ld ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      SZ_WORD: value = word;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed MIPS data memory with registered loads, misalignment strobe and
// a post-reset clear sweep. Define DATA_MEMORY_DEBUG_DUMP_EN to drive memorias.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int                   WORD_ADDR_WIDTH = 4,
  parameter int                   DUMP_WORDS      = 10,
  parameter logic [WORD_BITS-1:0] CLEAR_VALUE     = 32'h0
) (
  input  logic                            clka,
  input  logic                            reset,
  input  logic                            req,
  input  logic                            we,
  input  logic [1:0]                      size,
  input  logic                            unsigned_ld,
  input  logic [WORD_ADDR_WIDTH+1:0]      addr,
  input  logic [WORD_BITS-1:0]            wdata,
  output logic [WORD_BITS-1:0]            rdata,
  output logic                            rvalid,
  output logic                            misalign,
  output logic                            busy,
  output logic [WORD_BITS*DUMP_WORDS-1:0] memorias
);

  localparam int DEPTH = 2 ** WORD_ADDR_WIDTH;
  localparam logic [WORD_ADDR_WIDTH-1:0] LAST_IDX = WORD_ADDR_WIDTH'(DEPTH - 1);

  logic [WORD_BITS-1:0]       mem [DEPTH];
  state_e                     state;
  logic [WORD_ADDR_WIDTH-1:0] clr_ptr;
  logic [WORD_ADDR_WIDTH-1:0] widx;
  logic [1:0]                 offset;
  logic                       accept;
  logic                       mis;
  logic [WORD_BITS-1:0]       cur_word;
  logic [WORD_BITS-1:0]       merged;
  logic [WORD_BITS-1:0]       load_val;

  assign widx     = addr[WORD_ADDR_WIDTH+1:2];
  assign offset   = addr[1:0];
  assign accept   = req && !busy;
  assign mis      = is_misaligned(size, offset);
  assign cur_word = mem[widx];

  // Read-modify-write of the addressed word; unselected lanes keep their value.
  always_comb begin
    merged = cur_word;
    case (size_e'(size))
      SZ_BYTE: merged[8*offset +: 8]     = wdata[7:0];
      SZ_HALF: merged[16*offset[1] +: 16] = wdata[15:0];
      SZ_WORD: merged                    = wdata;
      default: merged                    = cur_word;
    endcase
  end

  mem_load_align u_align (
    .word        (cur_word),
    .offset      (offset),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .value       (load_val)
  );

  // The array has no reset; the sweep is the only thing that initialises it.
  always_ff @(posedge clka) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= CLEAR_VALUE;
    end else if (accept && we && !mis) begin
      mem[widx] <= merged;
    end
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      busy     <= 1'b1;
      rdata    <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_IDX) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (mis) begin
              rvalid   <= 1'b1;
              misalign <= 1'b1;
              rdata    <= '0;
            end else if (!we) begin
              rvalid <= 1'b1;
              rdata  <= load_val;
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

`ifdef DATA_MEMORY_DEBUG_DUMP_EN
  for (genvar i = 0; i < DUMP_WORDS; i++) begin : g_dump
    assign memorias[WORD_BITS*(DUMP_WORDS-i)-1 -: WORD_BITS] = mem[i];
  end
`else
  assign memorias = '0;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: load results and misalign strobes
// are queued when a request is driven and compared when rvalid appears.
module tb_data_memory_ctrl;

  logic         clka = 1'b0;
  logic         reset = 1'b1;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [1:0]   size = 2'b10;
  logic         unsigned_ld = 1'b0;
  logic [5:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         misalign;
  logic         busy;
  logic [319:0] memorias;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        exp_mis_q[$];
  logic [31:0] mdl [16];

  always #5 clka = ~clka;

  data_memory_ctrl dut (
    .clka        (clka),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .misalign    (misalign),
    .busy        (busy),
    .memorias    (memorias)
  );

  // Scoreboard: every rvalid must match the oldest queued expectation.
  always @(negedge clka) begin
    if (misalign && !rvalid) begin
      checks++; errors++;
      $display("FAIL misalign_without_rvalid: misalign=%0b rvalid=%0b", misalign, rvalid);
    end
    if (rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got rdata=%08h misalign=%0b, none expected", rdata, misalign);
      end else begin
        logic [31:0] ed;
        logic        em;
        ed = exp_q.pop_front();
        em = exp_mis_q.pop_front();
        if (rdata !== ed || misalign !== em) begin
          errors++;
          $display("FAIL load_result: got rdata=%08h misalign=%0b, want rdata=%08h misalign=%0b",
                   rdata, misalign, ed, em);
        end
      end
    end
  end

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic u);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (sz)
      2'b00:   return u ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Drives one request for one cycle; called and returns on a negedge.
  task automatic access(input logic w, input logic [1:0] sz, input logic u, input logic [5:0] a,
                        input logic [31:0] d, input logic ev, input logic [31:0] ed,
                        input logic em);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
    if (ev) begin
      exp_q.push_back(ed);
      exp_mis_q.push_back(em);
    end
    if (w && !em) begin
      case (sz)
        2'b00:   mdl[a[5:2]][8*a[1:0] +: 8] = d[7:0];
        2'b01:   mdl[a[5:2]][16*a[1] +: 16] = d[15:0];
        default: mdl[a[5:2]] = d;
      endcase
    end
    @(negedge clka);
  endtask

  task automatic store(input logic [1:0] sz, input logic [5:0] a, input logic [31:0] d);
    access(1'b1, sz, 1'b0, a, d, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic load(input logic [1:0] sz, input logic u, input logic [5:0] a,
                      input logic [31:0] ed);
    access(1'b0, sz, u, a, 32'h0, 1'b1, ed, 1'b0);
  endtask

  task automatic idle();
    req = 1'b0;
    @(negedge clka);
  endtask

  task automatic drain();
    req = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clka);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d loads outstanding, want 0", exp_q.size());
      exp_q.delete();
      exp_mis_q.delete();
    end
  endtask

  // Called on a negedge just after reset release; counts busy cycles.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      checks++;
      if (rvalid !== 1'b0 || misalign !== 1'b0) begin
        errors++;
        $display("FAIL busy_strobe: rvalid=%0b misalign=%0b during sweep, want 0", rvalid, misalign);
      end
      n++;
      @(negedge clka);
    end
    req = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; addr = 6'h3C;
    repeat (3) @(negedge clka);
    checks++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || misalign !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b rvalid=%0b misalign=%0b rdata=%08h, want 1 0 0 0",
               busy, rvalid, misalign, rdata);
    end
    reset = 1'b0;
    wait_sweep(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, want 16", n);
    end
    load(2'b10, 1'b0, 6'h3C, 32'h0);
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL load_latency: rvalid=%0b one cycle after accept, want 1", rvalid);
    end
    idle();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_strobe: rvalid=%0b two cycles after accept, want 0", rvalid);
    end
    drain();
  endtask

  task automatic test_byte_loads();
    store(2'b10, 6'h08, 32'h8899AABB);
    load(2'b00, 1'b0, 6'h08, 32'hFFFFFFBB);
    load(2'b00, 1'b0, 6'h09, 32'hFFFFFFAA);
    load(2'b00, 1'b0, 6'h0A, 32'hFFFFFF99);
    load(2'b00, 1'b0, 6'h0B, 32'hFFFFFF88);
    load(2'b00, 1'b1, 6'h0B, 32'h00000088);
    load(2'b00, 1'b1, 6'h08, 32'h000000BB);
    drain();
    checks++;
    if (rdata !== 32'h000000BB) begin
      errors++;
      $display("FAIL rdata_hold: got %08h, want 000000bb", rdata);
    end
  endtask

  task automatic test_halfword();
    store(2'b10, 6'h04, 32'hFFFFFFFF);
    store(2'b01, 6'h06, 32'h00001234);
    load(2'b10, 1'b0, 6'h04, 32'h1234FFFF);
    load(2'b01, 1'b0, 6'h04, 32'hFFFFFFFF);
    load(2'b01, 1'b1, 6'h04, 32'h0000FFFF);
    load(2'b01, 1'b0, 6'h06, 32'h00001234);
    load(2'b10, 1'b1, 6'h08, 32'h8899AABB);
    drain();
  endtask

  task automatic test_misalign();
    access(1'b1, 2'b10, 1'b0, 6'h05, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    access(1'b0, 2'b01, 1'b0, 6'h03, 32'h0, 1'b1, 32'h0, 1'b1);
    access(1'b0, 2'b11, 1'b0, 6'h04, 32'h0, 1'b1, 32'h0, 1'b1);
    access(1'b1, 2'b11, 1'b0, 6'h04, 32'h55555555, 1'b1, 32'h0, 1'b1);
    access(1'b1, 2'b01, 1'b0, 6'h07, 32'h0000ABCD, 1'b1, 32'h0, 1'b1);
    load(2'b10, 1'b0, 6'h04, 32'h1234FFFF);
    load(2'b00, 1'b0, 6'h07, 32'h00000012);
    load(2'b01, 1'b0, 6'h02, 32'h00000000);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  a;
    logic [1:0]  sz;
    logic        u;
    store(2'b10, 6'h10, 32'hA5A55A5A);
    load(2'b10, 1'b0, 6'h10, 32'hA5A55A5A);
    store(2'b00, 6'h11, 32'h000000C3);
    load(2'b00, 1'b1, 6'h11, 32'h000000C3);
    for (int i = 0; i < 16; i++) store(2'b10, 6'(i * 4), $urandom);
    for (int i = 0; i < 8; i++) begin
      sz = 2'($urandom_range(0, 1));
      a = 6'($urandom_range(0, 63));
      if (sz == 2'b01) a[0] = 1'b0;
      store(sz, a, $urandom);
    end
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      a = 6'($urandom_range(0, 63));
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      u = 1'($urandom_range(0, 1));
      load(sz, u, a, ld_model(mdl[a[5:2]], a[1:0], sz, u));
    end
    drain();
  endtask

  task automatic test_dump();
    store(2'b10, 6'h00, 32'hDEADBEEF);
    checks++;
`ifdef DATA_MEMORY_DEBUG_DUMP_EN
    if (memorias[319:288] !== 32'hDEADBEEF || memorias[31:0] !== mdl[9]) begin
      errors++;
      $display("FAIL dump: mem0=%08h mem9=%08h, want deadbeef %08h",
               memorias[319:288], memorias[31:0], mdl[9]);
    end
`else
    if (memorias !== '0) begin
      errors++;
      $display("FAIL dump_tied: memorias=%h, want 0", memorias);
    end
`endif
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    store(2'b10, 6'h3C, 32'h5A5A5A5A);
    load(2'b10, 1'b0, 6'h3C, 32'h5A5A5A5A);
    drain();
    reset = 1'b1;
    @(negedge clka);
    reset = 1'b0;
    repeat (7) @(posedge clka);
    @(negedge clka);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_sweep: busy=%0b, want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%0b rdata=%08h rvalid=%0b, want 1 0 0", busy, rdata, rvalid);
    end
    @(negedge clka);
    reset = 1'b0;
    wait_sweep(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL restart_busy_cycles: got %0d, want 16", n);
    end
    load(2'b10, 1'b0, 6'h3C, 32'h0);
    load(2'b10, 1'b0, 6'h00, 32'h0);
    load(2'b10, 1'b0, 6'h20, 32'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_halfword();
    test_misalign();
    test_back_to_back();
    test_dump();
    test_reset_mid_sweep();
    repeat (2) @(negedge clka);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised MIPS data memory: next generation of the 16x32 word store.
- Byte-addressed with byte, halfword and word loads/stores, sign/zero-extended loads, registered read with valid strobe, misalignment flag.
- Reset triggers a hardware clear sweep, one word per cycle, with a busy flag.
- Sits in the MEM stage between the ALU address path and the write-back mux.

Parameters:
- WORD_ADDR_WIDTH, 4: word-index bits; depth = 2**WORD_ADDR_WIDTH words of 32 bits.
- DUMP_WORDS, 10: words exported on the debug dump port (1..depth).
- CLEAR_VALUE, 32'h0: value written to every word by the clear sweep.

Ports:
- clka  in  1  clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request, valid for one cycle.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- unsigned_ld  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- addr  in  WORD_ADDR_WIDTH+2  byte address; word index = addr[MSB:2], offset = addr[1:0].
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, registered.
- rvalid  out  1  one-cycle strobe qualifying rdata.
- misalign  out  1  one-cycle error strobe.
- busy  out  1  high while clear sweep runs; requests ignored.
- memorias  out  32*DUMP_WORDS  debug dump, mem[0] in MSBs.

Behaviour:
- Async reset: state=CLEAR, clr_ptr=0, busy=1, rdata=0, rvalid=0, misalign=0. Array contents are not touched by the async reset itself.
- CLEAR state:
  - Each cycle writes CLEAR_VALUE to mem[clr_ptr], then clr_ptr++.
  - The write at clr_ptr = depth-1 moves the FSM to RUN; busy falls the following cycle.
  - Total: depth cycles of busy=1 after reset release.
- Reset asserted mid-sweep restarts the sweep from 0.
- RUN state: a request is accepted when req=1 and busy=0. While busy=1, req is dropped silently (no rvalid, no misalign).
- Alignment:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
  - size=11 is always misaligned.
  - Misaligned access: no array write; next cycle misalign=1, rvalid=1, rdata=0.
- Store lanes (little-endian; offset 0 = bits 7:0):
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Halfword: lanes addr[1]*2+{0,1} ← wdata[15:0].
  - Word: all four lanes.
  - Other lanes are unchanged. No rvalid on stores.
- Load:
  - 1-cycle latency: rdata/rvalid update on the edge after acceptance.
  - Extracted lane is extended per unsigned_ld; word loads ignore unsigned_ld.
  - rdata holds its value between loads; rvalid is low otherwise.
- Store at cycle N, load of the same word at N+1: returns the updated data (write committed at edge N).
- Back-to-back loads every cycle: full throughput, no bubbles.
- memorias is combinational from the array and reflects a store on the edge that commits it.

Optional Feature:
- Macro DATA_MEMORY_DEBUG_DUMP_EN.
- Defined: memorias = {mem[0], …, mem[DUMP_WORDS-1]}.
- Undefined: memorias is tied to 0 (port kept for a stable port list); no dump mux is synthesised.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL;
  - FSM state encodings ST_CLEAR, ST_RUN;
  - width constant WORD_BITS=32.
- One combinational sub-module, mem_load_align: (word, offset, size, unsigned_ld) → 32-bit extended load value. Store lane-merge stays inline.

Test Plan:
- Reset, release, hold req=1 throughout → busy=1 for exactly 16 cycles, no rvalid; then load of addr 0x3C → rdata=0, rvalid one cycle later.
- Word store 0x8899AABB at 0x08; byte loads at 0x08..0x0B, signed → 0xFFFFFFBB, 0xFFFFFFAA, 0xFFFFFF99, 0xFFFFFF88; unsigned at 0x0B → 0x00000088.
- Halfword store 0x1234 at 0x06 over 0xFFFFFFFF → word load 0x04 = 0x1234FFFF; signed half load 0x04 → 0xFFFFFFFF.
- Word store at 0x05, half load at 0x03, size=11 → misalign and rvalid pulse, rdata=0, array unchanged.
- Store at 0x10 cycle N, load 0x10 at N+1 → new data at N+2; reset asserted mid-sweep at ptr 7 → busy restarts, 16 more cycles.
- With DATA_MEMORY_DEBUG_DUMP_EN: store 0xDEADBEEF at 0x00 → memorias[319:288]=0xDEADBEEF; without macro → memorias=0.
